// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with double-buffered content.
// The shadow buffer commits only at frame end, so the display never tears.
module sevseg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  CLK100,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   hex_i,
    input  logic [7*DIGITS-1:0]   raw_i,
    input  logic [DIGITS-1:0]     mode_i,
    input  logic [DIGITS-1:0]     en_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  frame_o,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  DP
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef struct packed {
        logic [4*DIGITS-1:0] hex;
        logic [7*DIGITS-1:0] raw;
        logic [DIGITS-1:0]   mode;
        logic [DIGITS-1:0]   en;
        logic [DIGITS-1:0]   dp;
    } content_t;

    // Active-low {A..G}, MSB = segment A.
    function automatic logic [6:0] hexfont(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    content_t          disp_q, disp_d;
    content_t          shadow_q, shadow_d;
    logic              busy_q, busy_d;
    logic              frame_q, frame_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic cnt_wrap;
    logic frame_end;
    logic blank;

    always_comb begin
        cnt_wrap  = (cnt_q == CNT_LAST);
        frame_end = cnt_wrap && (idx_q == IDX_LAST);

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A pending shadow blocks new loads until it has been committed.
    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        busy_d   = busy_q;
        if (busy_q) begin
            if (frame_end) begin
                disp_d = shadow_q;
                busy_d = 1'b0;
            end
        end else if (load_i) begin
            shadow_d.hex  = hex_i;
            shadow_d.raw  = raw_i;
            shadow_d.mode = mode_i;
            shadow_d.en   = en_i;
            shadow_d.dp   = dp_i;
            busy_d        = 1'b1;
        end
    end

    // Outputs decode next-state so the registers line up with cnt/idx.
    always_comb begin
        frame_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        blank   = (BLANK_CYCLES > 0) && (cnt_d < BLANK_END);
        an_d    = '1;
        seg_d   = '1;
        dp_d    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((idx_d == IW'(i)) && !blank && disp_d.en[i]) begin
                an_d[i] = 1'b0;
                if (disp_d.mode[i]) begin
                    seg_d = ~disp_d.raw[7*i +: 7];
                end else begin
                    seg_d = hexfont(disp_d.hex[4*i +: 4]);
                end
                dp_d = ~disp_d.dp[i];
            end
        end
    end

    always_ff @(posedge CLK100 or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            frame_q  <= 1'b0;
            an_q     <= '1;
            seg_q    <= '1;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            frame_q  <= frame_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign busy_o  = busy_q;
    assign frame_o = frame_q;
    assign AN      = an_q;
    assign SEG     = seg_q;
    assign DP      = dp_q;

endmodule
